alarm_clock_ctrl: RTL and testbench

Mode controller and timekeeping sequencer for the alarm clock. Consumes the one-cycle second tick from the second counter, keeps hours/minutes/seconds, drives the counter's synchronous clear while time is being set, and runs the set-mode state machine from two buttons. It also compares wall time against the stored alarm and drives the ringing output with dismiss/snooze handling.

---
 rtl/alarm_pkg.sv | 38 +++
 rtl/wrap_counter.sv | 41 ++++
 rtl/alarm_clock_ctrl.sv | 158 +++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm clock controller: mode encoding,
// field widths/limits and the wrapped minute-addition helper.
package alarm_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_HOUR  = 3'd1,
    SET_MIN   = 3'd2,
    SET_AHOUR = 3'd3,
    SET_AMIN  = 3'd4
  } mode_e;

  // Returns {hh, mm} advanced by delta minutes (delta <= 59), wrapping at 24 h.
  function automatic logic [HOUR_W+MIN_W-1:0] add_minutes(
    input logic [HOUR_W-1:0] hh,
    input logic [MIN_W-1:0]  mm,
    input logic [MIN_W-1:0]  delta
  );
    logic [MIN_W:0]    sum;
    logic [HOUR_W-1:0] h;
    sum = {1'b0, mm} + {1'b0, delta};
    h   = hh;
    if (sum > {1'b0, MIN_MAX}) begin
      sum = sum - 7'd60;
      h   = (hh == HOUR_MAX) ? {HOUR_W{1'b0}} : hh + 5'd1;
    end else begin
      h   = hh;
    end
    return {h, sum[MIN_W-1:0]};
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap pulses on the
// increment that rolls MAX back to zero.
module wrap_counter #(
  parameter int unsigned    W   = 6,
  parameter logic [W-1:0]   MAX = 6'd59
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] value_q, value_d;

  assign wrap  = inc && !clr && (value_q == MAX);
  assign value = value_q;

  // Next value: clear wins over increment.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = {W{1'b0}};
    end else if (inc) begin
      value_d = (value_q == MAX) ? {W{1'b0}} : value_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      value_d = value_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= {W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock mode FSM, timekeeping, alarm compare and ringing control.
// Define ALARM_SNOOZE_EN to build the snooze target registers and re-ring path.
module alarm_clock_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sec_tick,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_snooze,
  input  logic              alarm_en,
  output logic              sec_clr,
  output logic [2:0]        mode,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [MIN_W-1:0]  seconds,
  output logic [HOUR_W-1:0] alarm_hours,
  output logic [MIN_W-1:0]  alarm_minutes,
  output logic              ringing
);

  mode_e             mode_q, mode_d;
  logic              sec_clr_q, ring_q, ring_d;
  logic              mode_adv, dismiss, inc_ok, time_run, enter_set, tick_ok;
  logic              sec_wrap, min_wrap, hr_wrap, ahr_wrap, amin_wrap;
  logic              at_zero, alarm_hit, snooze_hit;
  logic [HOUR_W-1:0] nxt_hr;
  logic [MIN_W-1:0]  nxt_min;
  logic              unused_wraps;

  // A mode press while ringing is a dismiss, never a mode step.
  assign mode_adv  = btn_mode && !ring_q;
  assign dismiss   = ring_q && (btn_mode || btn_snooze);
  assign inc_ok    = btn_inc && !btn_mode && !btn_snooze;
  assign time_run  = (mode_q != SET_HOUR) && (mode_q != SET_MIN);
  assign enter_set = mode_adv && (mode_q == RUN);
  assign tick_ok   = sec_tick && time_run && !enter_set;

  wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_sec (
    .clk(clk), .reset_n(reset_n), .inc(tick_ok), .clr(enter_set),
    .value(seconds), .wrap(sec_wrap));

  wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .reset_n(reset_n),
    .inc(sec_wrap || (inc_ok && (mode_q == SET_MIN))), .clr(1'b0),
    .value(minutes), .wrap(min_wrap));

  wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk(clk), .reset_n(reset_n),
    .inc((min_wrap && time_run) || (inc_ok && (mode_q == SET_HOUR))), .clr(1'b0),
    .value(hours), .wrap(hr_wrap));

  wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_ahour (
    .clk(clk), .reset_n(reset_n), .inc(inc_ok && (mode_q == SET_AHOUR)), .clr(1'b0),
    .value(alarm_hours), .wrap(ahr_wrap));

  wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_amin (
    .clk(clk), .reset_n(reset_n), .inc(inc_ok && (mode_q == SET_AMIN)), .clr(1'b0),
    .value(alarm_minutes), .wrap(amin_wrap));

  assign unused_wraps = hr_wrap ^ ahr_wrap ^ amin_wrap;

  // Compare against the hh:mm this tick is about to produce.
  assign nxt_min   = (minutes == MIN_MAX) ? {MIN_W{1'b0}} : minutes + 6'd1;
  assign nxt_hr    = (minutes != MIN_MAX) ? hours :
                     (hours == HOUR_MAX) ? {HOUR_W{1'b0}} : hours + 5'd1;
  assign at_zero   = tick_ok && (mode_q == RUN) && alarm_en && (seconds == MIN_MAX);
  assign alarm_hit = at_zero && (nxt_hr == alarm_hours) && (nxt_min == alarm_minutes);

`ifdef ALARM_SNOOZE_EN
  localparam logic [MIN_W-1:0] SNOOZE_DELTA = MIN_W'(SNOOZE_MIN);

  logic                     snz_pend_q, snz_pend_d;
  logic [HOUR_W+MIN_W-1:0]  snz_tgt_q, snz_tgt_d;

  assign snooze_hit = at_zero && snz_pend_q && ({nxt_hr, nxt_min} == snz_tgt_q);

  // Snooze arm/cancel; any ring or dismiss consumes the pending target.
  always_comb begin
    snz_pend_d = snz_pend_q;
    snz_tgt_d  = snz_tgt_q;
    if (!alarm_en) begin
      snz_pend_d = 1'b0;
    end else if (alarm_hit || snooze_hit) begin
      snz_pend_d = 1'b0;
    end else if (ring_q && btn_mode) begin
      snz_pend_d = 1'b0;
    end else if (ring_q && btn_snooze) begin
      snz_pend_d = 1'b1;
      snz_tgt_d  = add_minutes(hours, minutes, SNOOZE_DELTA);
    end else begin
      snz_pend_d = snz_pend_q;
    end
  end

  // Snooze state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snz_pend_q <= 1'b0;
      snz_tgt_q  <= {(HOUR_W+MIN_W){1'b0}};
    end else begin
      snz_pend_q <= snz_pend_d;
      snz_tgt_q  <= snz_tgt_d;
    end
  end
`else
  localparam int unsigned unused_snooze_min = SNOOZE_MIN;
  assign snooze_hit = 1'b0;
`endif

  // Mode sequencing and ringing next state.
  always_comb begin
    mode_d = mode_q;
    ring_d = ring_q;
    if (mode_adv) begin
      case (mode_q)
        RUN:       mode_d = SET_HOUR;
        SET_HOUR:  mode_d = SET_MIN;
        SET_MIN:   mode_d = SET_AHOUR;
        SET_AHOUR: mode_d = SET_AMIN;
        SET_AMIN:  mode_d = RUN;
        default:   mode_d = RUN;
      endcase
    end else begin
      mode_d = mode_q;
    end
    if (!alarm_en) begin
      ring_d = 1'b0;
    end else if (alarm_hit || snooze_hit) begin
      ring_d = 1'b1;
    end else if (dismiss) begin
      ring_d = 1'b0;
    end else begin
      ring_d = ring_q;
    end
  end

  // State registers; sec_clr is decoded from the next mode so it tracks mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= RUN;
      sec_clr_q <= 1'b0;
      ring_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      sec_clr_q <= (mode_d == SET_HOUR) || (mode_d == SET_MIN);
      ring_q    <= ring_d;
    end
  end

  assign mode    = mode_q;
  assign sec_clr = sec_clr_q;
  assign ringing = ring_q;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Scoreboard bench for alarm_clock_ctrl: a time-of-day model predicts every
// cycle's outputs; a monitor pops and compares them independently of stimulus.
module tb_alarm_clock_ctrl;

  localparam int SNZ = 5;

  logic       clk, reset_n, sec_tick, btn_mode, btn_inc, btn_snooze, alarm_en;
  logic       sec_clr, ringing;
  logic [2:0] mode;
  logic [4:0] hours, alarm_hours;
  logic [5:0] minutes, seconds, alarm_minutes;

  alarm_clock_ctrl #(.SNOOZE_MIN(SNZ)) dut (
    .clk(clk), .reset_n(reset_n), .sec_tick(sec_tick), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .btn_snooze(btn_snooze), .alarm_en(alarm_en),
    .sec_clr(sec_clr), .mode(mode), .hours(hours), .minutes(minutes),
    .seconds(seconds), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .ringing(ringing));

  typedef struct {
    int md; int hh; int mm; int ss; int ah; int am; int rg; int cl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model: t = seconds of day, al = alarm minute of day, snz = snooze minute of day.
  int t = 0, al = 0, md = 0, ring = 0, pend = 0, snz = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mode", int'(mode), e.md);
      chk("hours", int'(hours), e.hh);
      chk("minutes", int'(minutes), e.mm);
      chk("seconds", int'(seconds), e.ss);
      chk("alarm_hours", int'(alarm_hours), e.ah);
      chk("alarm_minutes", int'(alarm_minutes), e.am);
      chk("ringing", int'(ringing), e.rg);
      chk("sec_clr", int'(sec_clr), e.cl);
    end
  end

  task automatic model(input bit tk, input bit bm, input bit bi, input bit bs);
    int  old_min, nt, mm;
    bit  hit, shit, adv, inc, frozen;
    if (!reset_n) begin
      t = 0; al = 0; md = 0; ring = 0; pend = 0; snz = 0;
      return;
    end
    old_min = t / 60;
    hit = 0; shit = 0;
    adv = bm && !ring;
    inc = bi && !bm && !bs;
    frozen = (md == 1) || (md == 2);
    if (adv && md == 0) begin
      t = old_min * 60;
    end else if (tk && !frozen) begin
      nt = (t + 1) % 86400;
      if (md == 0 && alarm_en && nt % 60 == 0) begin
        hit  = (nt / 60 == al);
        shit = pend && (nt / 60 == snz);
      end
      t = nt;
    end
    if (inc) begin
      mm = (t / 60) % 60;
      case (md)
        1: t = (((t / 3600) + 1) % 24) * 3600 + (t % 3600);
        2: t = t - mm * 60 + ((mm + 1) % 60) * 60;
        3: al = (((al / 60) + 1) % 24) * 60 + (al % 60);
        4: al = (al / 60) * 60 + ((al % 60) + 1) % 60;
        default: ;
      endcase
    end
    if (!alarm_en) begin
      ring = 0; pend = 0;
    end else if (hit || shit) begin
      ring = 1; pend = 0;
    end else if (ring && bm) begin
      ring = 0; pend = 0;
    end else if (ring && bs) begin
      ring = 0;
`ifdef ALARM_SNOOZE_EN
      pend = 1;
      snz  = (old_min + SNZ) % 1440;
`endif
    end
    if (adv) md = (md + 1) % 5;
  endtask

  task automatic step(input bit tk, input bit bm, input bit bi, input bit bs);
    exp_t e;
    sec_tick = tk; btn_mode = bm; btn_inc = bi; btn_snooze = bs;
    model(tk, bm, bi, bs);
    e.md = md; e.hh = t / 3600; e.mm = (t / 60) % 60; e.ss = t % 60;
    e.ah = al / 60; e.am = al % 60; e.rg = ring; e.cl = (md == 1 || md == 2) ? 1 : 0;
    sb.push_back(e);
    @(negedge clk);
    sec_tick = 0; btn_mode = 0; btn_inc = 0; btn_snooze = 0;
  endtask

  task automatic press(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    int tgt, guard;
    clk = 0; reset_n = 0; alarm_en = 0;
    sec_tick = 0; btn_mode = 0; btn_inc = 0; btn_snooze = 0;
    @(negedge clk);
    step(0, 0, 0, 0);
    step(1, 1, 1, 0);
    chk("reset_mode", int'(mode), 0);
    chk("reset_ringing", int'(ringing), 0);
    reset_n = 1;

    // Set 23:59 and cross midnight with the alarm disabled.
    press(1);
    chk("set_hour_sec_clr", int'(sec_clr), 1);
    incs(23); press(1); incs(59); press(1);
    chk("set_ahour_sec_clr", int'(sec_clr), 0);
    press(2);
    ticks(59);
    chk("pre_midnight_sec", int'(seconds), 59);
    ticks(1);
    chk("midnight_h", int'(hours), 0);
    chk("midnight_m", int'(minutes), 0);
    chk("midnight_ring", int'(ringing), 0);

    // Time 07:30, alarm 07:31, ring after 60 ticks, dismiss with mode.
    press(1); incs(7); press(1); incs(30); press(1); incs(7); press(1); incs(31); press(1);
    chk("run_after_set", int'(mode), 0);
    chk("alarm_min_31", int'(alarm_minutes), 31);
    alarm_en = 1;
    ticks(59);
    chk("no_ring_early", int'(ringing), 0);
    ticks(1);
    chk("ring_0731", int'(ringing), 1);
    step(0, 1, 0, 0);
    chk("dismiss_ring", int'(ringing), 0);
    chk("dismiss_mode", int'(mode), 0);

    // Alarm to 07:32, ring, snooze; re-ring at 07:37 only with snooze.
    press(4); incs(1); press(1);
    ticks(60);
    chk("ring_0732", int'(ringing), 1);
    step(0, 0, 0, 1);
    chk("snooze_clears", int'(ringing), 0);
    ticks(299);
    chk("snooze_quiet", int'(ringing), 0);
    ticks(1);
`ifdef ALARM_SNOOZE_EN
    chk("snooze_rering", int'(ringing), 1);
`else
    chk("no_rering", int'(ringing), 0);
`endif
    alarm_en = 0; step(0, 0, 0, 0);
    chk("alarm_en_off_ring", int'(ringing), 0);
    alarm_en = 1;

    // Mode beats inc in the same cycle.
    press(1);
    step(0, 1, 1, 0);
    chk("prio_mode", int'(mode), 2);
    chk("prio_hours", int'(hours), 7);
    press(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) alarm_en = ~alarm_en;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    // Arm the alarm for the next minute, then reset while ringing.
    alarm_en = 0; step(0, 0, 0, 0);
    guard = 0;
    while (md != 0 && guard < 6) begin press(1); guard++; end
    press(3);
    tgt = (t / 60 + 1) % 1440;
    incs(((tgt / 60) - (al / 60) + 24) % 24);
    press(1);
    incs(((tgt % 60) - (al % 60) + 60) % 60);
    press(1);
    alarm_en = 1;
    ticks(60);
    chk("ring_before_reset", int'(ringing), 1);
    #2 reset_n = 0;
    #1;
    chk("async_rst_ring", int'(ringing), 0);
    chk("async_rst_hours", int'(hours), 0);
    chk("async_rst_alarm_m", int'(alarm_minutes), 0);
    chk("async_rst_mode", int'(mode), 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    reset_n = 1;
    ticks(60);
    chk("no_ring_after_reset", int'(ringing), 0);

    guard = 0;
    while (sb.size() > 0 && guard < 5) begin @(negedge clk); guard++; end
    if (sb.size() > 0) chk("scoreboard_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
